// File: rtl/apb_master_if.sv
// Command/response handshake plus shared APB bus between the system-side requester,
// the APB requester block and the GPIO/UART slaves.
interface apb_master_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic              cmd_sel;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] pAdd;
    logic [DATA_W-1:0] pwData;
    logic              pwr;
    logic [1:0]        psel;
    logic              pen;
    logic [DATA_W-1:0] prdata_gpio;
    logic [DATA_W-1:0] prdata_uart;
    logic              pready_gpio;
    logic              pready_uart;

    modport master (
        input  cmd_valid, cmd_wr, cmd_sel, cmd_addr, cmd_wdata,
        input  prdata_gpio, prdata_uart, pready_gpio, pready_uart,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output pAdd, pwData, pwr, psel, pen
    );

    modport slave (
        output cmd_valid, cmd_wr, cmd_sel, cmd_addr, cmd_wdata,
        output prdata_gpio, prdata_uart, pready_gpio, pready_uart,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  pAdd, pwData, pwr, psel, pen
    );
endinterface

// File: rtl/apb_master.sv
// APB3 requester: turns single system commands into SETUP/ACCESS transfers to the
// GPIO or UART slave, returning read data or a timeout error on a one-cycle strobe.
module apb_master #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    apb_master_if.master        bus
);
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic [1:0]        psel_q, psel_d;
    logic              pen_q, pen_d;
    logic              pwr_q, pwr_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    // Only the selected slave's handshake is observed.
    logic              sel_ready;
    logic [DATA_W-1:0] sel_rdata;
    logic              timeout_hit;

    assign sel_ready   = psel_q[1] ? bus.pready_uart : bus.pready_gpio;
    assign sel_rdata   = psel_q[1] ? bus.prdata_uart : bus.prdata_gpio;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            psel_q      <= 2'b00;
            pen_q       <= 1'b0;
            pwr_q       <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            psel_q      <= psel_d;
            pen_q       <= pen_d;
            pwr_q       <= pwr_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_ready_d = cmd_ready_q;
        psel_d      = psel_q;
        pen_d       = pen_q;
        pwr_d       = pwr_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    paddr_d     = bus.cmd_addr;
                    pwdata_d    = bus.cmd_wdata;
                    pwr_d       = bus.cmd_wr;
                    psel_d      = bus.cmd_sel ? 2'b10 : 2'b01;
                    cmd_ready_d = 1'b0;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                pen_d   = 1'b1;
                cnt_d   = CNT_W'(0);
                state_d = ACCESS;
            end
            ACCESS: begin
                // A ready slave wins over a timeout landing on the same edge.
                if (sel_ready) begin
                    if (!pwr_q) rsp_rdata_d = sel_rdata;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    psel_d      = 2'b00;
                    pen_d       = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end else if (timeout_hit) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    psel_d      = 2'b00;
                    pen_d       = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                psel_d      = 2'b00;
                pen_d       = 1'b0;
                cmd_ready_d = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.psel      = psel_q;
    assign bus.pen       = pen_q;
    assign bus.pwr       = pwr_q;
    assign bus.pAdd      = paddr_q;
    assign bus.pwData    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: transaction-level model checked every cycle, plus directed
// transfers with hand-computed expectations.
module tb_apb_master;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    apb_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_t counts cycles since acceptance (0 = no transfer in flight).
    int          m_t     = 0;
    logic        m_sel   = 1'b0;
    logic        m_wr    = 1'b0;
    logic [31:0] m_addr  = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rdata = '0;
    logic        m_valid = 1'b0;
    logic        m_err   = 1'b0;
    logic        m_rdy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t = 0; m_sel = 1'b0; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
            m_rdata = '0; m_valid = 1'b0; m_err = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (m_t == 0) begin
                if (bus.cmd_valid) begin
                    m_t = 1; m_sel = bus.cmd_sel; m_wr = bus.cmd_wr;
                    m_addr = bus.cmd_addr; m_wdata = bus.cmd_wdata;
                end
            end else if (m_t == 1) begin
                m_t = 2;
            end else begin
                m_rdy = m_sel ? bus.pready_uart : bus.pready_gpio;
                if (m_rdy) begin
                    m_valid = 1'b1; m_err = 1'b0; m_t = 0;
                    if (!m_wr) m_rdata = m_sel ? bus.prdata_uart : bus.prdata_gpio;
                end else if (TIMEOUT != 0 && (m_t - 1) == int'(TIMEOUT)) begin
                    m_valid = 1'b1; m_err = 1'b1; m_rdata = '0; m_t = 0;
                end else begin
                    m_t = m_t + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("cmd_ready", 64'(bus.cmd_ready), 64'(m_t == 0));
        check("psel", 64'(bus.psel), (m_t == 0) ? 64'd0 : (m_sel ? 64'd2 : 64'd1));
        check("pen", 64'(bus.pen), 64'(m_t >= 2));
        check("pwr", 64'(bus.pwr), 64'(m_wr));
        check("pAdd", 64'(bus.pAdd), 64'(m_addr));
        check("pwData", 64'(bus.pwData), 64'(m_wdata));
        check("rsp_valid", 64'(bus.rsp_valid), 64'(m_valid));
        check("rsp_err", 64'(bus.rsp_err), 64'(m_err));
        check("rsp_rdata", 64'(bus.rsp_rdata), 64'(m_rdata));
    end

    // Issue one command and hold the selected pready low for 'waits' ACCESS cycles
    // (waits < 0: never ready). Called and returns at a negedge.
    task automatic xfer(input logic sel, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int waits,
                        output int pen_cyc, output bit got);
        int n = 0;
        pen_cyc = 0;
        got     = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_sel = sel; bus.cmd_wr = wr;
        bus.cmd_addr  = addr; bus.cmd_wdata = wdata;
        bus.pready_uart = !sel;
        bus.pready_gpio = sel;
        while (!bus.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 64'(bus.cmd_ready), 64'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("setup_psel", 64'(bus.psel), sel ? 64'd2 : 64'd1);
        check("setup_pen", 64'(bus.pen), 64'd0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                got = 1'b1;
                break;
            end
            if (bus.pen) begin
                pen_cyc++;
                if (sel) bus.pready_uart = (waits >= 0) && (pen_cyc > waits);
                else     bus.pready_gpio = (waits >= 0) && (pen_cyc > waits);
            end
        end
        check("rsp_seen", 64'(got), 64'd1);
        bus.pready_uart = 1'b0;
        bus.pready_gpio = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int  pc, idx, comps, first, last, pen_tot;
        bit  got, pend;
        bus.cmd_valid = 1'b0; bus.cmd_wr = 1'b0; bus.cmd_sel = 1'b0;
        bus.cmd_addr = '0; bus.cmd_wdata = '0;
        bus.prdata_gpio = '0; bus.prdata_uart = '0;
        bus.pready_gpio = 1'b0; bus.pready_uart = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_psel", 64'(bus.psel), 64'd0);
        check("rst_pen", 64'(bus.pen), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_pAdd", 64'(bus.pAdd), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_cmd_ready", 64'(bus.cmd_ready), 64'd1);

        // UART write, zero wait
        xfer(1'b1, 1'b1, 32'd15, 32'h4142_4344, 0, pc, got);
        check("t1_pen_cycles", 64'(pc), 64'd1);
        check("t1_err", 64'(bus.rsp_err), 64'd0);
        check("t1_pAdd", 64'(bus.pAdd), 64'd15);
        check("t1_pwData", 64'(bus.pwData), 64'h4142_4344);
        check("t1_pwr", 64'(bus.pwr), 64'd1);
        check("t1_rdata", 64'(bus.rsp_rdata), 64'd0);

        // GPIO read; UART prdata must be ignored
        bus.prdata_gpio = 32'hA5A5_0F0F;
        bus.prdata_uart = 32'hFFFF_FFFF;
        xfer(1'b0, 1'b0, 32'd4, 32'h0, 0, pc, got);
        check("t3_rdata", 64'(bus.rsp_rdata), 64'hA5A5_0F0F);
        check("t3_pwr", 64'(bus.pwr), 64'd0);
        check("t3_err", 64'(bus.rsp_err), 64'd0);

        // UART write with 5 wait states; read data must be retained
        xfer(1'b1, 1'b1, 32'd20, 32'h1234_5678, 5, pc, got);
        check("t2_pen_cycles", 64'(pc), 64'd6);
        check("t2_err", 64'(bus.rsp_err), 64'd0);
        check("t2_rdata_kept", 64'(bus.rsp_rdata), 64'hA5A5_0F0F);

        // Timeout on UART read, then a normal read
        xfer(1'b1, 1'b0, 32'd8, 32'h0, -1, pc, got);
        check("t4_pen_cycles", 64'(pc), 64'd16);
        check("t4_err", 64'(bus.rsp_err), 64'd1);
        check("t4_rdata", 64'(bus.rsp_rdata), 64'd0);
        check("t4_psel", 64'(bus.psel), 64'd0);
        check("t4_pen", 64'(bus.pen), 64'd0);
        xfer(1'b1, 1'b0, 32'd8, 32'h0, 0, pc, got);
        check("t4b_err", 64'(bus.rsp_err), 64'd0);
        check("t4b_rdata", 64'(bus.rsp_rdata), 64'hFFFF_FFFF);

        // Reset in the middle of ACCESS wait states
        bus.cmd_valid = 1'b1; bus.cmd_sel = 1'b1; bus.cmd_wr = 1'b1;
        bus.cmd_addr = 32'h30; bus.cmd_wdata = 32'hDEAD_BEEF;
        bus.pready_uart = 1'b0; bus.pready_gpio = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_pen_before", 64'(bus.pen), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_psel", 64'(bus.psel), 64'd0);
        check("t5_pen", 64'(bus.pen), 64'd0);
        check("t5_pwr", 64'(bus.pwr), 64'd0);
        check("t5_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk);
        bus.pready_gpio = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("t5_psel_after", 64'(bus.psel), 64'd0);

        // Back-to-back: cmd_valid held for 4 zero-wait UART writes
        idx = 0; comps = 0; first = -1; last = -1; pen_tot = 0; pend = 1'b0;
        bus.cmd_sel = 1'b1; bus.cmd_wr = 1'b1; bus.cmd_addr = 32'h100;
        bus.cmd_wdata = 32'hB000_0000; bus.pready_uart = 1'b1; bus.cmd_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (pend) begin
                idx++;
                if (idx < 4) bus.cmd_wdata = 32'hB000_0000 + 32'(idx);
                else         bus.cmd_valid = 1'b0;
            end
            pend = bus.cmd_valid && bus.cmd_ready;
            if (bus.pen) pen_tot++;
            if (bus.rsp_valid) begin
                comps++;
                if (first < 0) first = c;
                last = c;
            end
            @(negedge clk);
        end
        bus.pready_uart = 1'b0;
        check("t6_accepts", 64'(idx), 64'd4);
        check("t6_completions", 64'(comps), 64'd4);
        check("t6_pen_cycles", 64'(pen_tot), 64'd4);
        check("t6_spacing", 64'(last - first), 64'd9);
        check("t6_last_pwData", 64'(bus.pwData), 64'hB000_0003);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
